iwht4x4_recon: RTL and testbench

//  Inverse 4x4 Walsh-Hadamard transform. Sits directly downstream of the hard-threshold filter in the denoise path.

---
 rtl/iwht_pkg.sv | 28 ++
 rtl/iwht4x4_recon_wht4_1d.sv | 31 +++
 rtl/iwht4x4_recon.sv | 183 ++++++++++++++++++
 tb/tb_iwht4x4_recon.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iwht_pkg.sv
// Shared constants and helpers for the 4x4 inverse Walsh-Hadamard reconstruction.
// Stage widths are expressed as growth over the coefficient width WIDTH0.
package iwht_pkg;

    localparam int S1_GROW   = 2;   // row pass:    WIDTH0 + 2
    localparam int S2_GROW   = 4;   // column pass: WIDTH0 + 4
    localparam int RND_BIAS  = 8;
    localparam int RND_SHIFT = 4;

    function automatic int idx(input int r, input int c);
        return 4 * r + c;
    endfunction

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/iwht4x4_recon_wht4_1d.sv
// Combinational 4-point Walsh-Hadamard butterfly; outputs grow by two bits so no overflow.
module wht4_1d #(
    parameter int W = 13
) (
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    output logic [W+1:0] y0,
    output logic [W+1:0] y1,
    output logic [W+1:0] y2,
    output logic [W+1:0] y3
);

    logic signed [W+1:0] a;
    logic signed [W+1:0] b;
    logic signed [W+1:0] c;
    logic signed [W+1:0] d;

    always_comb begin
        a  = $signed(x0) + $signed(x1);
        b  = $signed(x0) - $signed(x1);
        c  = $signed(x2) + $signed(x3);
        d  = $signed(x2) - $signed(x3);
        y0 = a + c;
        y1 = b + d;
        y2 = a - c;
        y3 = b - d;
    end

endmodule

// File: rtl/iwht4x4_recon.sv
// iwht4x4_recon: 3-stage pipelined inverse 4x4 WHT (row pass, column pass, round/saturate).
// Build option IWHT_NNZ_EN adds a per-block nonzero-coefficient count on blk_onnz.
module iwht4x4_recon
    import iwht_pkg::*;
#(
    parameter int WIDTH0 = 13,
    parameter int WIDTH1 = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH0-1:0] blk_i0,
    input  logic [WIDTH0-1:0] blk_i1,
    input  logic [WIDTH0-1:0] blk_i2,
    input  logic [WIDTH0-1:0] blk_i3,
    input  logic [WIDTH0-1:0] blk_i4,
    input  logic [WIDTH0-1:0] blk_i5,
    input  logic [WIDTH0-1:0] blk_i6,
    input  logic [WIDTH0-1:0] blk_i7,
    input  logic [WIDTH0-1:0] blk_i8,
    input  logic [WIDTH0-1:0] blk_i9,
    input  logic [WIDTH0-1:0] blk_i10,
    input  logic [WIDTH0-1:0] blk_i11,
    input  logic [WIDTH0-1:0] blk_i12,
    input  logic [WIDTH0-1:0] blk_i13,
    input  logic [WIDTH0-1:0] blk_i14,
    input  logic [WIDTH0-1:0] blk_i15,
    input  logic              blk_ivalid,
    output logic              blk_iready,
    output logic [WIDTH1-1:0] blk_o0,
    output logic [WIDTH1-1:0] blk_o1,
    output logic [WIDTH1-1:0] blk_o2,
    output logic [WIDTH1-1:0] blk_o3,
    output logic [WIDTH1-1:0] blk_o4,
    output logic [WIDTH1-1:0] blk_o5,
    output logic [WIDTH1-1:0] blk_o6,
    output logic [WIDTH1-1:0] blk_o7,
    output logic [WIDTH1-1:0] blk_o8,
    output logic [WIDTH1-1:0] blk_o9,
    output logic [WIDTH1-1:0] blk_o10,
    output logic [WIDTH1-1:0] blk_o11,
    output logic [WIDTH1-1:0] blk_o12,
    output logic [WIDTH1-1:0] blk_o13,
    output logic [WIDTH1-1:0] blk_o14,
    output logic [WIDTH1-1:0] blk_o15,
    output logic [4:0]        blk_onnz,
    output logic              blk_ovalid,
    input  logic              blk_oready
);

    localparam int W_S1 = WIDTH0 + S1_GROW;
    localparam int W_S2 = WIDTH0 + S2_GROW;

    logic [WIDTH0-1:0] x     [16];
    logic [W_S1-1:0]   row_y [16];
    logic [W_S2-1:0]   col_y [16];
    logic [W_S1-1:0]   s1_q  [16];
    logic [W_S1-1:0]   s1_d  [16];
    logic [W_S2-1:0]   s2_q  [16];
    logic [W_S2-1:0]   s2_d  [16];
    logic [WIDTH1-1:0] s3_q  [16];
    logic [WIDTH1-1:0] s3_d  [16];
    logic signed [31:0] rnd   [16];
    logic signed [31:0] clamp [16];
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic en1, en2, en3;

    assign x[0]  = blk_i0;   assign x[1]  = blk_i1;   assign x[2]  = blk_i2;   assign x[3]  = blk_i3;
    assign x[4]  = blk_i4;   assign x[5]  = blk_i5;   assign x[6]  = blk_i6;   assign x[7]  = blk_i7;
    assign x[8]  = blk_i8;   assign x[9]  = blk_i9;   assign x[10] = blk_i10;  assign x[11] = blk_i11;
    assign x[12] = blk_i12;  assign x[13] = blk_i13;  assign x[14] = blk_i14;  assign x[15] = blk_i15;

    // Handshake: a block moves across a port on every rising edge where valid and ready are
    // both high. Each stage loads whenever it is empty or its downstream neighbour loads, so
    // ready ripples back from blk_oready only and never depends on blk_ivalid.
    always_comb begin
        en3 = !v3_q || blk_oready;
        en2 = !v2_q || en3;
        en1 = !v1_q || en2;
    end

    assign blk_iready = en1;
    assign blk_ovalid = v3_q;

    for (genvar r = 0; r < 4; r++) begin : g_row
        wht4_1d #(.W(WIDTH0)) u_row (
            .x0(x[idx(r, 0)]),     .x1(x[idx(r, 1)]),     .x2(x[idx(r, 2)]),     .x3(x[idx(r, 3)]),
            .y0(row_y[idx(r, 0)]), .y1(row_y[idx(r, 1)]), .y2(row_y[idx(r, 2)]), .y3(row_y[idx(r, 3)])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        wht4_1d #(.W(W_S1)) u_col (
            .x0(s1_q[idx(0, c)]),  .x1(s1_q[idx(1, c)]),  .x2(s1_q[idx(2, c)]),  .x3(s1_q[idx(3, c)]),
            .y0(col_y[idx(0, c)]), .y1(col_y[idx(1, c)]), .y2(col_y[idx(2, c)]), .y3(col_y[idx(3, c)])
        );
    end

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        for (int i = 0; i < 16; i++) begin
            s1_d[i] = s1_q[i];
            s2_d[i] = s2_q[i];
            s3_d[i] = s3_q[i];
            // Round half up before the divide-by-16 normalisation, then clamp.
            rnd[i]   = 32'($signed(s2_q[i])) + RND_BIAS;
            clamp[i] = sat(rnd[i] >>> RND_SHIFT, WIDTH1);
        end
        if (en1) begin
            v1_d = blk_ivalid;
            for (int i = 0; i < 16; i++) s1_d[i] = row_y[i];
        end
        if (en2) begin
            v2_d = v1_q;
            for (int i = 0; i < 16; i++) s2_d[i] = col_y[i];
        end
        if (en3) begin
            v3_d = v2_q;
            for (int i = 0; i < 16; i++) s3_d[i] = clamp[i][WIDTH1-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
                s3_q[i] <= '0;
            end
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            for (int i = 0; i < 16; i++) begin
                s1_q[i] <= s1_d[i];
                s2_q[i] <= s2_d[i];
                s3_q[i] <= s3_d[i];
            end
        end
    end

`ifdef IWHT_NNZ_EN
    logic [4:0] nnz_cnt;
    logic [4:0] nnz1_q, nnz1_d, nnz2_q, nnz2_d, nnz3_q, nnz3_d;

    // The count rides alongside the data using the same enables, so it stays block-aligned.
    always_comb begin
        nnz_cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i] != '0) nnz_cnt = nnz_cnt + 5'd1;
        end
        nnz1_d = en1 ? nnz_cnt : nnz1_q;
        nnz2_d = en2 ? nnz1_q  : nnz2_q;
        nnz3_d = en3 ? nnz2_q  : nnz3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nnz1_q <= 5'd0;
            nnz2_q <= 5'd0;
            nnz3_q <= 5'd0;
        end else begin
            nnz1_q <= nnz1_d;
            nnz2_q <= nnz2_d;
            nnz3_q <= nnz3_d;
        end
    end

    assign blk_onnz = nnz3_q;
`else
    assign blk_onnz = 5'd0;
`endif

    assign blk_o0  = s3_q[0];   assign blk_o1  = s3_q[1];   assign blk_o2  = s3_q[2];   assign blk_o3  = s3_q[3];
    assign blk_o4  = s3_q[4];   assign blk_o5  = s3_q[5];   assign blk_o6  = s3_q[6];   assign blk_o7  = s3_q[7];
    assign blk_o8  = s3_q[8];   assign blk_o9  = s3_q[9];   assign blk_o10 = s3_q[10];  assign blk_o11 = s3_q[11];
    assign blk_o12 = s3_q[12];  assign blk_o13 = s3_q[13];  assign blk_o14 = s3_q[14];  assign blk_o15 = s3_q[15];

endmodule

// File: tb/tb_iwht4x4_recon.sv
// Scoreboard bench for iwht4x4_recon: a 13-bit-output instance and a 10-bit-output instance
// share stimulus; expected blocks come from a sign-table Hadamard model and hand-picked vectors.
module tb_iwht4x4_recon;

    localparam int W0 = 13;
    localparam int W1 = 13;
    localparam int WN = 10;

`ifdef IWHT_NNZ_EN
    localparam bit NNZ_EN = 1'b1;
`else
    localparam bit NNZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0][W1-1:0] w;
        logic [15:0][WN-1:0] n;
        logic [4:0]          nnz;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    // Coefficient of input x_k in output y_m of the 4-point transform.
    localparam int SGN [4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W0-1:0] blk_i [16];
    logic blk_ivalid = 1'b0;
    logic blk_iready;
    logic [W1-1:0] blk_o [16];
    logic [4:0] blk_onnz;
    logic blk_ovalid;
    logic blk_oready = 1'b1;
    logic n_iready, n_ovalid;
    logic [WN-1:0] n_o [16];
    logic [4:0] n_onnz;

    int n_cmp = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    logic [EXP_W-1:0] exp_q [$];
    logic [EXP_W-1:0] exp_next;

    always #5 clk = ~clk;

    iwht4x4_recon #(.WIDTH0(W0), .WIDTH1(W1)) u_dut (
        .clk(clk), .rst(rst),
        .blk_i0(blk_i[0]),   .blk_i1(blk_i[1]),   .blk_i2(blk_i[2]),   .blk_i3(blk_i[3]),
        .blk_i4(blk_i[4]),   .blk_i5(blk_i[5]),   .blk_i6(blk_i[6]),   .blk_i7(blk_i[7]),
        .blk_i8(blk_i[8]),   .blk_i9(blk_i[9]),   .blk_i10(blk_i[10]), .blk_i11(blk_i[11]),
        .blk_i12(blk_i[12]), .blk_i13(blk_i[13]), .blk_i14(blk_i[14]), .blk_i15(blk_i[15]),
        .blk_ivalid(blk_ivalid), .blk_iready(blk_iready),
        .blk_o0(blk_o[0]),   .blk_o1(blk_o[1]),   .blk_o2(blk_o[2]),   .blk_o3(blk_o[3]),
        .blk_o4(blk_o[4]),   .blk_o5(blk_o[5]),   .blk_o6(blk_o[6]),   .blk_o7(blk_o[7]),
        .blk_o8(blk_o[8]),   .blk_o9(blk_o[9]),   .blk_o10(blk_o[10]), .blk_o11(blk_o[11]),
        .blk_o12(blk_o[12]), .blk_o13(blk_o[13]), .blk_o14(blk_o[14]), .blk_o15(blk_o[15]),
        .blk_onnz(blk_onnz), .blk_ovalid(blk_ovalid), .blk_oready(blk_oready)
    );

    iwht4x4_recon #(.WIDTH0(W0), .WIDTH1(WN)) u_dut_n (
        .clk(clk), .rst(rst),
        .blk_i0(blk_i[0]),   .blk_i1(blk_i[1]),   .blk_i2(blk_i[2]),   .blk_i3(blk_i[3]),
        .blk_i4(blk_i[4]),   .blk_i5(blk_i[5]),   .blk_i6(blk_i[6]),   .blk_i7(blk_i[7]),
        .blk_i8(blk_i[8]),   .blk_i9(blk_i[9]),   .blk_i10(blk_i[10]), .blk_i11(blk_i[11]),
        .blk_i12(blk_i[12]), .blk_i13(blk_i[13]), .blk_i14(blk_i[14]), .blk_i15(blk_i[15]),
        .blk_ivalid(blk_ivalid), .blk_iready(n_iready),
        .blk_o0(n_o[0]),   .blk_o1(n_o[1]),   .blk_o2(n_o[2]),   .blk_o3(n_o[3]),
        .blk_o4(n_o[4]),   .blk_o5(n_o[5]),   .blk_o6(n_o[6]),   .blk_o7(n_o[7]),
        .blk_o8(n_o[8]),   .blk_o9(n_o[9]),   .blk_o10(n_o[10]), .blk_o11(n_o[11]),
        .blk_o12(n_o[12]), .blk_o13(n_o[13]), .blk_o14(n_o[14]), .blk_o15(n_o[15]),
        .blk_onnz(n_onnz), .blk_ovalid(n_ovalid), .blk_oready(blk_oready)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int clip(input int t, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -hi - 1;
        if (t > hi) return hi;
        if (t < lo) return lo;
        return t;
    endfunction

    function automatic exp_t model(input int v [16]);
        exp_t e;
        int s, t, cnt;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        s += v[4*r+c] * SGN[r][i] * SGN[c][j];
                t = (s + 8) >>> 4;
                e.w[4*i+j] = W1'(clip(t, W1));
                e.n[4*i+j] = WN'(clip(t, WN));
            end
        end
        for (int i = 0; i < 16; i++) if (v[i] != 0) cnt++;
        e.nnz = NNZ_EN ? 5'(cnt) : 5'd0;
        return e;
    endfunction

    // Present one block and hold it until the handshake edge; returns just after that edge.
    task automatic send(input int v [16]);
        int t;
        for (int i = 0; i < 16; i++) blk_i[i] = W0'(v[i]);
        exp_next   = EXP_W'(model(v));
        blk_ivalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!blk_iready && t < 100);
        check("accept_timeout", {511'd0, blk_iready}, 512'd1);
        @(posedge clk);
        #2;
        blk_ivalid = 1'b0;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!blk_ovalid && k < 20);
    endtask

    // Send one block into an idle pipeline and require it on the third edge counting the accept edge.
    task automatic single(input int v [16]);
        int k;
        send(v);
        wait_out(k);
        check("latency", 512'(k), 512'd3);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t obs, held, e;
        logic held_vld;
        held_vld = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                obs.w[i] = blk_o[i];
                obs.n[i] = n_o[i];
            end
            obs.nnz = blk_onnz;
            if (rst) begin
                exp_q.delete();
                held_vld = 1'b0;
            end else begin
                if (blk_ivalid && blk_iready) begin
                    exp_q.push_back(exp_next);
                    acc_cnt++;
                end
                if (held_vld) check("hold_stable", 512'(obs), 512'(held));
                if (blk_ovalid && blk_oready) begin
                    check("out_expected", {511'd0, exp_q.size() != 0}, 512'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_t'(exp_q.pop_front());
                        check("data_w13", 512'(obs.w), 512'(e.w));
                        check("data_w10", 512'(obs.n), 512'(e.n));
                        check("nnz", 512'(obs.nnz), 512'(e.nnz));
                        check("nnz_w10", 512'(n_onnz), 512'(e.nnz));
                        check("hs_w10", {510'd0, n_ovalid, n_iready}, 512'd3);
                    end
                end
                held_vld = blk_ovalid && !blk_oready;
                held     = obs;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int v [16];
        int k, acc0, cnt;
        for (int i = 0; i < 16; i++) blk_i[i] = '0;
        exp_next = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ovalid", {511'd0, blk_ovalid}, 512'd0);
        check("rst_o0", 512'(blk_o[0]), 512'd0);
        check("rst_o15", 512'(blk_o[15]), 512'd0);
        check("rst_onnz", 512'(blk_onnz), 512'd0);
        check("rst_iready", {511'd0, blk_iready}, 512'd1);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Zero block, DC impulse, rounding edges, AC impulse, full-scale and a dense block.
        for (int i = 0; i < 16; i++) v[i] = 0;
        single(v);
        v[0] = 160;  single(v);
        v[0] = 8;    single(v);
        v[0] = -8;   single(v);
        v[0] = 0;  v[5] = 24;   single(v);
        v[5] = -24;  single(v);
        v[5] = 0;  v[1] = 16;   single(v);
        for (int i = 0; i < 16; i++) v[i] = 4095;
        single(v);
        for (int i = 0; i < 16; i++) v[i] = -4096;
        single(v);
        for (int i = 0; i < 16; i++) v[i] = (i % 3 == 0) ? -37 * i : 53 + i;
        single(v);

        // Six back-to-back blocks with the consumer stalled for edges 2..8.
        @(posedge clk);
        #2;
        acc0 = acc_cnt;
        fork
            begin
                int b [16];
                for (int n = 0; n < 6; n++) begin
                    for (int i = 0; i < 16; i++) b[i] = 0;
                    b[(3 * n + 2) % 16] = (n % 2 == 0) ? 48 + 32 * n : -40 - 16 * n;
                    b[15 - n] = 16 * (n + 1);
                    send(b);
                end
            end
            begin
                for (int r = 1; r <= 16; r++) begin
                    @(posedge clk);
                    #2;
                    blk_oready = !(r >= 2 && r <= 8);
                    @(negedge clk);
                    if (r >= 3 && r <= 8) check("stall_iready", {511'd0, blk_iready}, 512'd0);
                    if (r == 8) check("stall_accepts", 512'(acc_cnt - acc0), 512'd3);
                    if (r >= 9 && r <= 14) check("no_gap", {511'd0, blk_ovalid}, 512'd1);
                end
            end
        join
        blk_oready = 1'b1;
        repeat (6) @(posedge clk);
        #2;

        // Asynchronous reset with one block in S3 and one in S2.
        for (int i = 0; i < 16; i++) v[i] = 0;
        v[0] = 160;  send(v);
        v[0] = 0;  v[3] = 64;   send(v);
        @(posedge clk);
        #3;
        check("pre_rst_ovalid", {511'd0, blk_ovalid}, 512'd1);
        rst = 1'b1;
        #1;
        check("async_ovalid", {511'd0, blk_ovalid}, 512'd0);
        check("async_o0", 512'(blk_o[0]), 512'd0);
        check("async_o5", 512'(blk_o[5]), 512'd0);
        check("async_onnz", 512'(blk_onnz), 512'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        v[3] = 0;  v[10] = -96;
        single(v);
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (blk_ovalid) cnt++;
        end
        check("post_rst_extra", 512'(cnt), 512'd0);
        check("drained", 512'(exp_q.size()), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
